pc_gen_ras: RTL and testbench
=============================

# pc_gen_ras

Parametrised next-PC generator for the fetch stage: holds the architectural fetch PC and selects each cycle between misprediction repair, J/JAL target, JR return, BTB prediction and sequential PC+4. It adds a circular return-address stack (RAS) so JR returns are predicted at fetch, with a register-value fallback when the stack is empty. It sits between the BTB/branch-resolution logic and the instruction-memory address port.

## Interface
- XLEN, 32: address width; must be ≥ 32.
- RAS_DEPTH, 8: RAS entries; power of two, ≥ 2.
- RESET_PC, 0: fetch address loaded on reset.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  load-use hazard; freezes PC and RAS.
- mispredict  in  1  branch resolved wrong; highest priority.
- correct_pc  in  XLEN  repair address.
- jump  in  1  J/JAL in decode.
- jal  in  1  call; push link_addr (asserted together with jump).
- jump_target  in  26  J-format target field.
- jr  in  1  return in decode.
- jr_addr  in  XLEN  register-file value for JR fallback.
- link_addr  in  XLEN  return address to push.
- predict_taken  in  1  BTB hit, predicted taken.
- predicted_target  in  XLEN  BTB target.
- pc_out  out  XLEN  current fetch PC (registered).
- ras_empty  out  1  count == 0.
- ras_full  out  1  count == RAS_DEPTH.
- ras_hit  out  1  registered; 1 for one cycle after a JR served from the RAS.

## Operation
- pc_plus4 = pc_out + 4, modulo 2^XLEN (wraps silently).
- Next-PC priority, evaluated at each edge:
  1. mispredict → correct_pc (applied even when stall=1).
  2. else stall → hold pc_out; no RAS change.
  3. jump → {pc_plus4[XLEN-1:28], jump_target, 2'b00}.
  4. jr → RAS top if !ras_empty, else jr_addr.
  5. predict_taken → predicted_target.
  6. else → pc_plus4.
- RAS is a circular buffer: top pointer (log2 RAS_DEPTH bits) and count (0..RAS_DEPTH).
- Push (jal, not stalled, no mispredict): ptr+1 mod RAS_DEPTH, write link_addr, count saturates at RAS_DEPTH; on full the oldest entry is silently overwritten.
- Pop (jr, not stalled, no mispredict, count>0): read top, ptr−1 mod RAS_DEPTH, count−1. Pop on empty: no state change, jr_addr used, ras_hit=0.
- Push and pop in the same cycle: top entry replaced with link_addr; ptr and count unchanged; next PC is the old top.
- mispredict squashes any jal/jr in that cycle: no push/pop; RAS contents are not repaired.
- ras_hit ← jr && !ras_empty && !stall && !mispredict, else 0.

## Timing
- Reset (rst=1 at an edge): pc_out=RESET_PC, ptr=0, count=0, ras_hit=0; entries need not be cleared. Reset wins over all inputs; reset mid-sequence discards the stack.
- One-cycle latency: inputs sampled at edge N set pc_out after edge N.
- ras_empty/ras_full are combinational from count and reflect state after the last edge.
- No handshakes; all controls are single-cycle level-qualified by stall.

## Configuration
- RAS_EN defined: RAS as described.
- RAS_EN undefined: no RAS storage; jr always selects jr_addr; jal is ignored beyond jump; ras_empty=1, ras_full=0, ras_hit=0 constant.

## Structure
- Shared package pc_pkg: XLEN default, RESET_PC default, next-PC select enum (SEL_REPAIR, SEL_JUMP, SEL_RET, SEL_PRED, SEL_SEQ).
- One sub-module: ras_stack (RAS_DEPTH, XLEN), holding the circular storage, ptr, count and push/pop/replace logic; top-level holds the PC register and priority mux.

## Test plan
- Reset with RESET_PC=0x100, no controls for 3 cycles → pc_out 0x100, 0x104, 0x108, 0x10C.
- pc_out=0x00400000, jump=1, jal=1, jump_target=0x0000040, link_addr=0x00400004; next cycle jr=1 → pc_out 0x00000100, then 0x00400004, ras_hit=1, ras_empty=1.
- RAS_DEPTH=4: 5 pushes of 0xA0..0xB0 step 4, then 5 jr with jr_addr=0xDEAD0000 → returns 0xB0, 0xAC, 0xA8, 0xA4, then 0xDEAD0000 with ras_hit=0; ras_full=1 after the 4th push.
- stall=1 with jump=1 and mispredict=1, correct_pc=0x2000 → pc_out=0x2000, RAS count unchanged; stall=1 alone → pc_out held.
- jal and jr together with top=0x300, link_addr=0x400 → next pc_out=0x300, count unchanged, subsequent jr → 0x400.
- Build without RAS_EN: jal then jr with jr_addr=0x500 → pc_out=0x500, ras_hit=0, ras_empty=1.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage next-PC generator.
// Contents: default address width / reset PC and the next-PC select enum
// used by the priority mux in pc_gen_ras.
package pc_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // SEL_HOLD covers the stalled case, where the PC register keeps its value.
  typedef enum logic [2:0] {
    SEL_REPAIR = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_RET    = 3'd3,
    SEL_PRED   = 3'd4,
    SEL_SEQ    = 3'd5
  } next_sel_e;

endpackage

// File: rtl/pc_gen_ras_if.sv
// pc_gen_ras_if: control/address bundle between the decode/branch logic
// (master) and the next-PC generator (slave).
// Master drives: stall, mispredict, correct_pc, jump, jal, jump_target, jr,
//   jr_addr, link_addr, predict_taken, predicted_target.
// Slave drives:  pc_out, ras_empty, ras_full, ras_hit.
interface pc_gen_ras_if
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            stall;
  logic            mispredict;
  logic [XLEN-1:0] correct_pc;
  logic            jump;
  logic            jal;
  logic [25:0]     jump_target;
  logic            jr;
  logic [XLEN-1:0] jr_addr;
  logic [XLEN-1:0] link_addr;
  logic            predict_taken;
  logic [XLEN-1:0] predicted_target;
  logic [XLEN-1:0] pc_out;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_hit;

  modport master (
    output stall, mispredict, correct_pc, jump, jal, jump_target, jr,
           jr_addr, link_addr, predict_taken, predicted_target,
    input  pc_out, ras_empty, ras_full, ras_hit
  );

  modport slave (
    input  stall, mispredict, correct_pc, jump, jal, jump_target, jr,
           jr_addr, link_addr, predict_taken, predicted_target,
    output pc_out, ras_empty, ras_full, ras_hit
  );
endinterface

// File: rtl/pc_gen_ras_ras_stack.sv
// ras_stack: circular return-address stack.
// Ports: clk/rst (sync, active-high), i_push (qualified call), i_pop
//   (qualified return), i_link_addr (address to push), o_top (current top
//   entry), o_empty/o_full (from count), o_hit (registered: a pop was served).
// Macro RAS_EN: when undefined the stack has no storage and reports
//   permanently empty, never full, never hit.
module ras_stack #(
  parameter int RAS_DEPTH = 8,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_link_addr,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_hit
);
`ifdef RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic            r_hit;
  logic            w_do_pop;
  logic            w_do_push;
  logic            w_replace;
  logic [PW-1:0]   w_ptr_inc;

  assign o_empty   = (r_count == CW'(0));
  assign o_full    = (r_count == CW'(RAS_DEPTH));
  assign o_top     = r_mem[r_ptr];
  assign o_hit     = r_hit;
  // A pop on an empty stack is a no-op; a push+pop pair only becomes a
  // replace-in-place when there really is a top entry to consume.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_replace = i_push && w_do_pop;
  assign w_do_push = i_push && !w_do_pop;
  assign w_ptr_inc = r_ptr + PW'(1);

  // Pointer, occupancy count and hit flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_hit <= w_do_pop;
      if (w_replace) begin
        r_ptr   <= r_ptr;
        r_count <= r_count;
      end else if (w_do_push) begin
        r_ptr <= w_ptr_inc;
        // When full the oldest slot is overwritten, so count saturates.
        if (!o_full) r_count <= r_count + CW'(1);
      end else if (w_do_pop) begin
        r_ptr   <= r_ptr - PW'(1);
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Entry storage; contents are deliberately not cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_replace)      r_mem[r_ptr]     <= i_link_addr;
      else if (w_do_push) r_mem[w_ptr_inc] <= i_link_addr;
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{clk, rst, i_push, i_pop, i_link_addr};
  assign o_top    = '0;
  assign o_empty  = 1'b1;
  assign o_full   = 1'b0;
  assign o_hit    = 1'b0;
`endif
endmodule

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch-stage next-PC generator with a return-address stack.
// Ports: clk, rst (sync, active-high), bus (pc_gen_ras_if.slave) carrying the
//   stall/mispredict/jump/jal/jr/predict controls and addresses in, and
//   pc_out, ras_empty, ras_full, ras_hit out.
// Priority: mispredict > stall > jump > jr > predict_taken > pc+4.
// Macro RAS_EN: enables the return-address stack; without it jr always
//   returns to jr_addr.
module pc_gen_ras
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF)
) (
  input  logic        clk,
  input  logic        rst,
  pc_gen_ras_if.slave bus
);
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_ras_hit;
  logic            w_push;
  logic            w_pop;
  next_sel_e       w_sel;

  assign w_pc_plus4 = r_pc + XLEN'(4);
  // A stalled or squashed cycle must leave the stack untouched.
  assign w_push = bus.jal && !bus.stall && !bus.mispredict;
  assign w_pop  = bus.jr  && !bus.stall && !bus.mispredict;

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_link_addr (bus.link_addr),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (w_ras_full),
    .o_hit       (w_ras_hit)
  );

  // Next-PC source selection by fixed priority.
  always_comb begin
    w_sel = SEL_SEQ;
    if (bus.mispredict)         w_sel = SEL_REPAIR;
    else if (bus.stall)         w_sel = SEL_HOLD;
    else if (bus.jump)          w_sel = SEL_JUMP;
    else if (bus.jr)            w_sel = SEL_RET;
    else if (bus.predict_taken) w_sel = SEL_PRED;
    else                        w_sel = SEL_SEQ;
  end

  // Next-PC value for the selected source.
  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_sel)
      SEL_REPAIR: w_next_pc = bus.correct_pc;
      SEL_HOLD:   w_next_pc = r_pc;
      SEL_JUMP:   w_next_pc = {w_pc_plus4[XLEN-1:28], bus.jump_target, 2'b00};
      SEL_RET:    w_next_pc = w_ras_empty ? bus.jr_addr : w_ras_top;
      SEL_PRED:   w_next_pc = bus.predicted_target;
      SEL_SEQ:    w_next_pc = w_pc_plus4;
      default:    w_next_pc = w_pc_plus4;
    endcase
  end

  // Architectural fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_next_pc;
  end

  assign bus.pc_out    = r_pc;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_full  = w_ras_full;
  assign bus.ras_hit   = w_ras_hit;
endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: self-checking bench for pc_gen_ras (XLEN=32, RAS_DEPTH=4,
// RESET_PC=0x100). Table vectors, directed stack sequences and random
// stimulus, all compared against a queue-based reference model.
module tb_pc_gen_ras;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;
`ifdef RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic        jump;
    logic        jal;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] link_addr;
    logic        predict_taken;
    logic [31:0] predicted_target;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] exp_pc;
  } tvec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_hit;

  pc_gen_ras_if #(.XLEN(32)) bus ();

  pc_gen_ras #(
    .XLEN      (32),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (RPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic in_t idle();
    in_t v;
    v.stall = 1'b0; v.mispredict = 1'b0; v.correct_pc = 32'h0;
    v.jump = 1'b0; v.jal = 1'b0; v.jump_target = 26'h0;
    v.jr = 1'b0; v.jr_addr = 32'h0; v.link_addr = 32'h0;
    v.predict_taken = 1'b0; v.predicted_target = 32'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    bus.stall = v.stall; bus.mispredict = v.mispredict; bus.correct_pc = v.correct_pc;
    bus.jump = v.jump; bus.jal = v.jal; bus.jump_target = v.jump_target;
    bus.jr = v.jr; bus.jr_addr = v.jr_addr; bus.link_addr = v.link_addr;
    bus.predict_taken = v.predict_taken; bus.predicted_target = v.predicted_target;
  endtask

  function automatic logic m_empty();
    return !RAS_ON || (m_q.size() == 0);
  endfunction

  function automatic logic m_full();
    return RAS_ON && (m_q.size() == DEPTH);
  endfunction

  // Reference model: the stack is a queue whose back is the top of stack.
  task automatic model_step(input in_t v);
    logic [31:0] p4;
    logic [31:0] nxt;
    logic        can_pop;
    m_hit = 1'b0;
    if (v.mispredict) nxt = v.correct_pc;
    else if (v.stall) nxt = m_pc;
    else begin
      p4 = m_pc + 32'd4;
      can_pop = !m_empty();
      if (v.jump)               nxt = {p4[31:28], v.jump_target, 2'b00};
      else if (v.jr)            nxt = can_pop ? m_q[m_q.size()-1] : v.jr_addr;
      else if (v.predict_taken) nxt = v.predicted_target;
      else                      nxt = p4;
      if (RAS_ON) begin
        if (v.jr && can_pop) begin
          m_hit = 1'b1;
          if (v.jal) m_q[m_q.size()-1] = v.link_addr;
          else       void'(m_q.pop_back());
        end else if (v.jal) begin
          if (m_q.size() == DEPTH) void'(m_q.pop_front());
          m_q.push_back(v.link_addr);
        end
      end
    end
    m_pc = nxt;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_pc"},    bus.pc_out,    m_pc);
    chk({tag, "_hit"},   {31'd0, bus.ras_hit},   {31'd0, m_hit});
    chk({tag, "_empty"}, {31'd0, bus.ras_empty}, {31'd0, m_empty()});
    chk({tag, "_full"},  {31'd0, bus.ras_full},  {31'd0, m_full()});
  endtask

  task automatic step(input string tag, input in_t v);
    drive(v);
    model_step(v);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset(input string tag);
    drive(idle());
    rst = 1'b1;
    m_pc = RPC;
    m_q.delete();
    m_hit = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_model(tag);
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.stall = ($urandom_range(3) == 0);
    v.mispredict = ($urandom_range(7) == 0);
    v.correct_pc = $urandom;
    v.jump = ($urandom_range(3) == 0);
    v.jal = v.jump ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
    v.jump_target = 26'($urandom);
    v.jr = ($urandom_range(3) == 0);
    v.jr_addr = $urandom;
    v.link_addr = $urandom;
    v.predict_taken = ($urandom_range(3) == 0);
    v.predicted_target = $urandom;
    return v;
  endfunction

  tvec_t tbl[14];
  in_t   v;

  initial begin
    // Table: mux priority, wrap and stall behaviour from an empty stack.
    for (int i = 0; i < 14; i++) begin
      tbl[i].in = idle();
      tbl[i].exp_pc = 32'h0;
    end
    tbl[0].exp_pc = 32'h0000_0104;
    tbl[1].exp_pc = 32'h0000_0108;
    tbl[2].exp_pc = 32'h0000_010C;
    tbl[3].in.jump = 1'b1; tbl[3].in.jump_target = 26'h3FF_FFFF;
    tbl[3].exp_pc = 32'h0FFF_FFFC;
    tbl[4].in.predict_taken = 1'b1; tbl[4].in.predicted_target = 32'h1234_5678;
    tbl[4].exp_pc = 32'h1234_5678;
    tbl[5].in.mispredict = 1'b1; tbl[5].in.correct_pc = 32'hFFFF_FFFC;
    tbl[5].in.jump = 1'b1; tbl[5].in.predict_taken = 1'b1;
    tbl[5].exp_pc = 32'hFFFF_FFFC;
    tbl[6].exp_pc = 32'h0000_0000;
    tbl[7].in.stall = 1'b1; tbl[7].in.jump = 1'b1; tbl[7].in.jump_target = 26'h55;
    tbl[7].exp_pc = 32'h0000_0000;
    tbl[8].in.stall = 1'b1; tbl[8].in.mispredict = 1'b1; tbl[8].in.correct_pc = 32'h2000;
    tbl[8].exp_pc = 32'h0000_2000;
    tbl[9].in.jr = 1'b1; tbl[9].in.jr_addr = 32'h0000_0777;
    tbl[9].exp_pc = 32'h0000_0777;
    tbl[10].in.jump = 1'b1; tbl[10].in.jump_target = 26'h10;
    tbl[10].in.predict_taken = 1'b1; tbl[10].in.predicted_target = 32'h9999_0000;
    tbl[10].exp_pc = 32'h0000_0040;
    tbl[11].in.jr = 1'b1; tbl[11].in.jr_addr = 32'h0000_0880;
    tbl[11].in.predict_taken = 1'b1; tbl[11].in.predicted_target = 32'h9999_0000;
    tbl[11].exp_pc = 32'h0000_0880;
    tbl[12].in.predict_taken = 1'b1; tbl[12].in.predicted_target = 32'hF000_0000;
    tbl[12].exp_pc = 32'hF000_0000;
    tbl[13].in.jump = 1'b1; tbl[13].in.jump_target = 26'h1;
    tbl[13].exp_pc = 32'hF000_0004;

    do_reset("reset");
    chk("reset_pc", bus.pc_out, 32'h0000_0100);
    for (int i = 0; i < 14; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].in);
      chk($sformatf("tbl%0d_exp_pc", i), bus.pc_out, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_exp_hit", i), {31'd0, bus.ras_hit}, 32'd0);
      chk($sformatf("tbl%0d_exp_empty", i), {31'd0, bus.ras_empty}, 32'd1);
    end

`ifdef RAS_EN
    // Call then return.
    v = idle(); v.mispredict = 1'b1; v.correct_pc = 32'h0040_0000;
    step("call_setup", v);
    v = idle(); v.jump = 1'b1; v.jal = 1'b1; v.jump_target = 26'h000_0040;
    v.link_addr = 32'h0040_0004;
    step("call", v);
    chk("call_pc", bus.pc_out, 32'h0000_0100);
    v = idle(); v.jr = 1'b1; v.jr_addr = 32'h1111_0000;
    step("ret", v);
    chk("ret_pc", bus.pc_out, 32'h0040_0004);
    chk("ret_hit", {31'd0, bus.ras_hit}, 32'd1);
    chk("ret_empty", {31'd0, bus.ras_empty}, 32'd1);

    // Overflow: five pushes into four entries, then five returns.
    do_reset("ovf_reset");
    for (int i = 0; i < 5; i++) begin
      v = idle(); v.jump = 1'b1; v.jal = 1'b1; v.jump_target = 26'h100;
      v.link_addr = 32'h0000_00A0 + 32'(4 * i);
      step("ovf_push", v);
      if (i == 3) chk("ovf_full4", {31'd0, bus.ras_full}, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      v = idle(); v.jr = 1'b1; v.jr_addr = 32'hDEAD_0000;
      step("ovf_pop", v);
      chk($sformatf("ovf_pop%0d_pc", i), bus.pc_out,
          (i < 4) ? (32'h0000_00B0 - 32'(4 * i)) : 32'hDEAD_0000);
      chk($sformatf("ovf_pop%0d_hit", i), {31'd0, bus.ras_hit}, (i < 4) ? 32'd1 : 32'd0);
    end

    // Mispredict during stall squashes a call; stall alone holds.
    do_reset("sq_reset");
    v = idle(); v.jal = 1'b1; v.link_addr = 32'h0000_0BBB;
    step("sq_push", v);
    v = idle(); v.stall = 1'b1; v.jump = 1'b1; v.jal = 1'b1; v.link_addr = 32'h0000_0CCC;
    v.mispredict = 1'b1; v.correct_pc = 32'h0000_2000;
    step("sq_mis", v);
    chk("sq_mis_pc", bus.pc_out, 32'h0000_2000);
    v = idle(); v.stall = 1'b1; v.jr = 1'b1;
    step("sq_stall", v);
    chk("sq_stall_pc", bus.pc_out, 32'h0000_2000);
    v = idle(); v.jr = 1'b1; v.jr_addr = 32'h1;
    step("sq_ret", v);
    chk("sq_ret_pc", bus.pc_out, 32'h0000_0BBB);
    chk("sq_ret_empty", {31'd0, bus.ras_empty}, 32'd1);

    // Simultaneous push and pop replaces the top entry.
    do_reset("rep_reset");
    v = idle(); v.jal = 1'b1; v.link_addr = 32'h0000_0300;
    step("rep_push", v);
    v = idle(); v.jal = 1'b1; v.jr = 1'b1; v.link_addr = 32'h0000_0400;
    step("rep_both", v);
    chk("rep_both_pc", bus.pc_out, 32'h0000_0300);
    chk("rep_both_empty", {31'd0, bus.ras_empty}, 32'd0);
    v = idle(); v.jr = 1'b1; v.jr_addr = 32'h2;
    step("rep_ret", v);
    chk("rep_ret_pc", bus.pc_out, 32'h0000_0400);
    chk("rep_ret_empty", {31'd0, bus.ras_empty}, 32'd1);
`else
    // Without the stack, a return always goes to the register value.
    do_reset("nr_reset");
    v = idle(); v.jump = 1'b1; v.jal = 1'b1; v.jump_target = 26'h40;
    v.link_addr = 32'h0000_0104;
    step("nr_call", v);
    v = idle(); v.jr = 1'b1; v.jr_addr = 32'h0000_0500;
    step("nr_ret", v);
    chk("nr_ret_pc", bus.pc_out, 32'h0000_0500);
    chk("nr_ret_hit", {31'd0, bus.ras_hit}, 32'd0);
    chk("nr_ret_empty", {31'd0, bus.ras_empty}, 32'd1);
`endif

    // Random stimulus with occasional mid-sequence resets.
    do_reset("rnd_reset");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(63) == 0) do_reset("rnd_rst");
      else step("rnd", rand_in());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
